// File: rtl/game_reg_shadow_pkg.sv
// Shared game definitions: default regfile indices of the frame-shadowed
// registers and the shadow controller state encoding.
package game_reg_shadow_pkg;

  localparam logic [4:0] DEF_BALL_REG   = 5'd20;
  localparam logic [4:0] DEF_NOTES1_REG = 5'd21;
  localparam logic [4:0] DEF_NOTES2_REG = 5'd22;
  localparam logic [4:0] DEF_INOUT_REG  = 5'd23;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } shadow_state_t;

endpackage

// File: rtl/shadow_slot.sv
// One shadowed register: staging value with dirty bit, a commit holding
// copy frozen at the frame_start edge, and the frame-stable shadow.
module shadow_slot (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        transfer,
  input  logic        commit,
  output logic [31:0] shadow,
  output logic        dirty,
  output logic        armed,
  output logic        overwrite
);

  logic [31:0] staging;
  logic [31:0] hold;

  // A write into a dirty slot loses a staged value, unless that value is
  // being frozen for commit on the same edge.
  assign overwrite = wr_en && dirty && !transfer;

  // Stage writes, freeze dirty data at frame_start, publish it in COMMIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      staging <= '0;
      hold    <= '0;
      shadow  <= '0;
      dirty   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      if (transfer) begin
        hold  <= staging;
        armed <= dirty;
        dirty <= 1'b0;
      end
      if (commit && armed) begin
        shadow <= hold;
        armed  <= 1'b0;
      end
      // NOTE: the later non-blocking assignment wins, so a write on the
      // frame_start edge leaves the slot dirty for the next frame.
      if (wr_en) begin
        staging <= wr_data;
        dirty   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_reg_shadow.sv
// Frame-synchronous shadow of the game registers: processor writes are
// staged and copied to the outputs only at vertical blank.
module game_reg_shadow
  import game_reg_shadow_pkg::*;
#(
  parameter logic [4:0] BALL_REG   = DEF_BALL_REG,
  parameter logic [4:0] NOTES1_REG = DEF_NOTES1_REG,
  parameter logic [4:0] NOTES2_REG = DEF_NOTES2_REG,
  parameter logic [4:0] INOUT_REG  = DEF_INOUT_REG
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_writeEnable,
  input  logic [4:0]  ctrl_writeReg,
  input  logic [31:0] data_writeReg,
  input  logic        frame_start,
  output logic [31:0] ball,
  output logic [31:0] notes1,
  output logic [31:0] notes2,
  output logic [31:0] in_out,
  output logic [10:0] ball_x_pos,
  output logic [10:0] ball_y_pos,
  output logic        pending,
  output logic        commit_pulse,
  output logic [15:0] frame_count,
  output logic [7:0]  overwrite_count
);

  shadow_state_t state;

  logic                 wr_ok;
  logic [NUM_SLOTS-1:0] hit;
  logic [NUM_SLOTS-1:0] slot_dirty;
  logic [NUM_SLOTS-1:0] slot_armed;
  logic [NUM_SLOTS-1:0] slot_ow;
  logic [31:0]          shadow_q [NUM_SLOTS];
  logic                 transfer;
  logic                 commit;

  // Index 0 is the hard-wired zero register and is never shadowed.
  assign wr_ok  = ctrl_writeEnable && (ctrl_writeReg != 5'd0);
  assign hit[0] = wr_ok && (ctrl_writeReg == BALL_REG);
  assign hit[1] = wr_ok && (ctrl_writeReg == NOTES1_REG);
  assign hit[2] = wr_ok && (ctrl_writeReg == NOTES2_REG);
  assign hit[3] = wr_ok && (ctrl_writeReg == INOUT_REG);

  assign transfer = (state == ST_PENDING) && frame_start;
  assign commit   = (state == ST_COMMIT);

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    shadow_slot u_slot (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (hit[i]),
      .wr_data   (data_writeReg),
      .transfer  (transfer),
      .commit    (commit),
      .shadow    (shadow_q[i]),
      .dirty     (slot_dirty[i]),
      .armed     (slot_armed[i]),
      .overwrite (slot_ow[i])
    );
  end

  assign ball       = shadow_q[0];
  assign notes1     = shadow_q[1];
  assign notes2     = shadow_q[2];
  assign in_out     = shadow_q[3];
  assign ball_x_pos = shadow_q[0][31:21];
  assign ball_y_pos = shadow_q[0][20:10];

  // Frozen-but-not-yet-published values still count as awaiting commit.
  assign pending = |(slot_dirty | slot_armed);

  // Commit sequencing plus the registered pulse and statistics counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      commit_pulse    <= 1'b0;
      frame_count     <= '0;
      overwrite_count <= '0;
    end else begin
      commit_pulse <= commit;
      if (commit) begin
        frame_count <= frame_count + 16'd1;
      end
      if ((|slot_ow) && (overwrite_count != 8'hFF)) begin
        overwrite_count <= overwrite_count + 8'd1;
      end
      case (state)
        ST_IDLE:    if (|hit) state <= ST_PENDING;
        ST_PENDING: if (frame_start) state <= ST_COMMIT;
        ST_COMMIT:  state <= ((|hit) || (|slot_dirty)) ? ST_PENDING : ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_reg_shadow.sv
// Self-checking bench for game_reg_shadow: directed scenarios followed by
// random traffic, all compared against a register-level behavioural model.
module tb_game_reg_shadow;

  logic        clock;
  logic        reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        frame_start;
  logic [31:0] ball, notes1, notes2, in_out;
  logic [10:0] ball_x_pos, ball_y_pos;
  logic        pending;
  logic        commit_pulse;
  logic [15:0] frame_count;
  logic [7:0]  overwrite_count;

  int total = 0;
  int bad   = 0;

  // Reference model: what the processor has staged, what the display sees,
  // and the snapshot taken at frame_start that becomes visible one edge later.
  logic [31:0] m_stage  [4];
  logic [31:0] m_shadow [4];
  logic [31:0] m_snap   [4];
  bit          m_dirty  [4];
  bit          m_snapv  [4];
  bit          m_inflight;
  bit          m_cp;
  int          m_fc;
  int          m_oc;

  game_reg_shadow dut (
    .clock            (clock),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .frame_start      (frame_start),
    .ball             (ball),
    .notes1           (notes1),
    .notes2           (notes2),
    .in_out           (in_out),
    .ball_x_pos       (ball_x_pos),
    .ball_y_pos       (ball_y_pos),
    .pending          (pending),
    .commit_pulse     (commit_pulse),
    .frame_count      (frame_count),
    .overwrite_count  (overwrite_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int slot_of(input logic [4:0] idx);
    if (idx >= 5'd20 && idx <= 5'd23) return int'(idx) - 20;
    return -1;
  endfunction

  task automatic model_edge(input logic we, input logic [4:0] idx, input logic [31:0] dat,
                            input logic fs, input logic rst);
    int  s;
    bit  any;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_stage[i] = '0; m_shadow[i] = '0; m_snap[i] = '0;
        m_dirty[i] = 0;  m_snapv[i]  = 0;
      end
      m_inflight = 0; m_cp = 0; m_fc = 0; m_oc = 0;
      return;
    end
    any = 0;
    for (int i = 0; i < 4; i++) any |= m_dirty[i];
    m_cp = m_inflight;
    if (m_inflight) begin
      for (int i = 0; i < 4; i++) begin
        if (m_snapv[i]) m_shadow[i] = m_snap[i];
        m_snapv[i] = 0;
      end
      m_inflight = 0;
      m_fc = (m_fc + 1) % 65536;
    end else if (fs && any) begin
      for (int i = 0; i < 4; i++) begin
        m_snapv[i] = m_dirty[i];
        m_snap[i]  = m_stage[i];
        m_dirty[i] = 0;
      end
      m_inflight = 1;
    end
    s = slot_of(idx);
    if (we && s >= 0) begin
      if (m_dirty[s] && m_oc < 255) m_oc++;
      m_stage[s] = dat;
      m_dirty[s] = 1;
    end
  endtask

  task automatic check_all(input string tag);
    bit mp;
    mp = m_inflight;
    for (int i = 0; i < 4; i++) mp |= m_dirty[i];
    check($sformatf("%s.ball", tag),   ball,   m_shadow[0]);
    check($sformatf("%s.notes1", tag), notes1, m_shadow[1]);
    check($sformatf("%s.notes2", tag), notes2, m_shadow[2]);
    check($sformatf("%s.in_out", tag), in_out, m_shadow[3]);
    check($sformatf("%s.x", tag), {21'b0, ball_x_pos}, {21'b0, m_shadow[0][31:21]});
    check($sformatf("%s.y", tag), {21'b0, ball_y_pos}, {21'b0, m_shadow[0][20:10]});
    check($sformatf("%s.pending", tag), {31'b0, pending}, {31'b0, mp});
    check($sformatf("%s.cpulse", tag), {31'b0, commit_pulse}, {31'b0, m_cp});
    check($sformatf("%s.fcount", tag), {16'b0, frame_count}, 32'(m_fc));
    check($sformatf("%s.ocount", tag), {24'b0, overwrite_count}, 32'(m_oc));
  endtask

  // One clock edge with the given inputs; outputs are checked 1 time unit later.
  task automatic cyc(input string tag, input logic we, input logic [4:0] idx,
                     input logic [31:0] dat, input logic fs, input logic rst);
    ctrl_writeEnable = we;
    ctrl_writeReg    = idx;
    data_writeReg    = dat;
    frame_start      = fs;
    reset            = rst;
    model_edge(we, idx, dat, fs, rst);
    @(posedge clock);
    #1;
    ctrl_writeEnable = 1'b0;
    frame_start      = 1'b0;
    reset            = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic        we, fs, rst;
    logic [4:0]  idx;
    logic [31:0] dat;

    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h0;
    frame_start      = 1'b0;
    reset            = 1'b1;

    // Reset state.
    cyc("rst0", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    cyc("rst1", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("rst.ball", ball, 32'h0);
    check("rst.fcount", {16'b0, frame_count}, 32'h0);

    // Ball write, commit two edges after frame_start.
    cyc("ball.wr", 1'b1, 5'd20, 32'h12345678, 1'b0, 1'b0);
    check("ball.pend", {31'b0, pending}, 32'h1);
    cyc("ball.fs", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    check("ball.early", ball, 32'h0);
    check("ball.nopulse", {31'b0, commit_pulse}, 32'h0);
    idle("ball.commit");
    check("ball.val", ball, 32'h12345678);
    check("ball.xpos", {21'b0, ball_x_pos}, 32'h091);
    check("ball.pulse", {31'b0, commit_pulse}, 32'h1);
    check("ball.fc1", {16'b0, frame_count}, 32'h1);
    idle("ball.after");
    check("ball.pulse_once", {31'b0, commit_pulse}, 32'h0);

    // Double write before commit.
    cyc("dbl.wr1", 1'b1, 5'd21, 32'hA, 1'b0, 1'b0);
    cyc("dbl.wr2", 1'b1, 5'd21, 32'hB, 1'b0, 1'b0);
    cyc("dbl.fs", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle("dbl.commit");
    check("dbl.notes1", notes1, 32'hB);
    check("dbl.ocount", {24'b0, overwrite_count}, 32'h1);

    // Write coinciding with frame_start belongs to the next frame.
    cyc("coin.pre", 1'b1, 5'd22, 32'h77, 1'b0, 1'b0);
    cyc("coin.fs", 1'b1, 5'd23, 32'h5, 1'b1, 1'b0);
    idle("coin.commit");
    check("coin.notes2", notes2, 32'h77);
    check("coin.inout0", in_out, 32'h0);
    check("coin.pend", {31'b0, pending}, 32'h1);
    cyc("coin.fs2", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle("coin.commit2");
    check("coin.inout5", in_out, 32'h5);
    check("coin.pend0", {31'b0, pending}, 32'h0);

    // Writes to unshadowed indices and frame_start in IDLE change nothing.
    cyc("ign.r0", 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cyc("ign.r7", 1'b1, 5'd7, 32'hCAFE_F00D, 1'b0, 1'b0);
    cyc("ign.fs", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    idle("ign.w1");
    idle("ign.w2");
    check("ign.ball", ball, 32'h12345678);
    check("ign.fc", {16'b0, frame_count}, 32'h4);
    check("ign.pend", {31'b0, pending}, 32'h0);

    // Reset in the COMMIT cycle discards the commit.
    cyc("rmc.wr", 1'b1, 5'd20, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc("rmc.fs", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    cyc("rmc.rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    check("rmc.ball", ball, 32'h0);
    check("rmc.pend", {31'b0, pending}, 32'h0);
    check("rmc.pulse", {31'b0, commit_pulse}, 32'h0);
    idle("rmc.after");
    check("rmc.pulse2", {31'b0, commit_pulse}, 32'h0);
    check("rmc.ball2", ball, 32'h0);

    // Overwrite counter saturation.
    for (int i = 0; i < 260; i++) cyc("sat", 1'b1, 5'd20, 32'(i), 1'b0, 1'b0);
    check("sat.ocount", {24'b0, overwrite_count}, 32'hFF);
    cyc("sat.rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0, 1, 2, 3: idx = 5'(20 + $urandom_range(0, 3));
        4:          idx = 5'd0;
        default:    idx = 5'($urandom_range(0, 31));
      endcase
      dat = $urandom;
      fs  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc("rnd", we, idx, dat, fs, rst);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
